spi_slave_core: RTL

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_edge_det.sv | 15 +
 rtl/spi_slave_core.sv | 81 ++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and default parameters shared by the SPI slave stages
package spi_pkg;
  typedef enum logic {IDLE, SHIFT} spi_state_t;
  localparam int SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_IDLE_TX = '1;
endpackage

// File: rtl/spi_edge_det.sv
// spi_edge_det: rise/fall strobes of an already-synchronised signal
module spi_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) prev <= 1'b0;
    else prev <= sig;
  assign rise = sig & ~prev;
  assign fall = ~sig & prev;
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: mode-0 SPI slave, MSB first, with rx/tx word handshakes
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_TX = '1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sck_in,
  input  logic             mosi_in,
  input  logic             cs_n_in,
  output logic             miso_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             overrun,
  output logic             underrun
);
  localparam int CW = $clog2(WIDTH);
  spi_state_t state, state_nx;
  logic rise, fall, start, active, word_end, load, done;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rx_sr, tx_sr, rx_word, tx_sr_nx;
  spi_edge_det u_sck (
    .clk(clk),
    .resetn(resetn),
    .sig(sck_in),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = cs_n_in ? IDLE : SHIFT;
    start    = state == IDLE && !cs_n_in;
    active   = state == SHIFT && !cs_n_in;
    word_end = active && rise && cnt == CW'(WIDTH - 1);
    // done marks that the next sck fall closes a word and reloads instead of shifting
    load     = start || (active && fall && done);
    rx_word  = {rx_sr[WIDTH-2:0], mosi_in};
    tx_sr_nx = cs_n_in ? IDLE_TX :
               load ? (tx_valid ? tx_data : IDLE_TX) :
               (active && fall) ? {tx_sr[WIDTH-2:0], 1'b1} : tx_sr;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt      <= '0;
      done     <= 1'b0;
      rx_sr    <= '0;
      tx_sr    <= IDLE_TX;
      miso_out <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tx_ready <= load && tx_valid;
      underrun <= load && !tx_valid;
      overrun  <= word_end && rx_valid && !rx_ready;
      tx_sr    <= tx_sr_nx;
      miso_out <= cs_n_in | tx_sr_nx[WIDTH-1];
      if (cs_n_in) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (active && rise) begin
        rx_sr <= rx_word;
        cnt   <= word_end ? '0 : cnt + CW'(1);
        done  <= word_end;
      end else if (load) done <= 1'b0;
      if (word_end && !(rx_valid && !rx_ready)) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule
